scan_csr_master: RTL and testbench

- Serial-scan front end that drives the control/status register block's register interface: reg_wen, reg_ren, cr_wdata, cr_rdata, sr_rdata and reg_ready.
- It deserialises 18-bit command frames from the scan pin.
- Each frame becomes either a one-cycle write pulse, or a read handshake that waits on reg_ready.
- Read results (status plus control, 32 bits) are captured and shifted back out on scan_out during the next frame, JTAG capture/shift style.

---
 rtl/scan_csr_if.sv | 26 ++
 rtl/scan_csr_master.sv | 82 ++++++++
 tb/tb_scan_csr_master.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/scan_csr_if.sv
// scan_csr_if: scan pins, CSR register interface and status flags of the scan master
interface scan_csr_if;
    logic        scan_en;
    logic        scan_in;
    logic        scan_out;
    logic        reg_wen;
    logic        reg_ren;
    logic [16:0] cr_wdata;
    logic [16:0] cr_rdata;
    logic [14:0] sr_rdata;
    logic        reg_ready;
    logic        busy;
    logic        rd_valid;
    logic        err_frame;
    logic        err_timeout;

    modport master (
        input  scan_en, scan_in, cr_rdata, sr_rdata, reg_ready,
        output scan_out, reg_wen, reg_ren, cr_wdata, busy, rd_valid, err_frame, err_timeout
    );

    modport slave (
        output scan_en, scan_in, cr_rdata, sr_rdata, reg_ready,
        input  scan_out, reg_wen, reg_ren, cr_wdata, busy, rd_valid, err_frame, err_timeout
    );
endinterface

// File: rtl/scan_csr_master.sv
// scan_csr_master: deserialises scan command frames into CSR writes/reads and scans read results back out
module scan_csr_master #(
    parameter int FRAME_LEN  = 18,
    parameter int RD_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    scan_csr_if.master bus
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, WR, RD} state_t;
    state_t               state, state_d;
    logic [FRAME_LEN-1:0] cmd;
    logic [31:0]          rsr;
    logic [5:0]           cnt;
    logic [TW-1:0]        tcnt;
    logic                 blocked;
    logic                 start, shift_en, good, bad, cap, tmo, ovr;

    assign bus.scan_out = rsr[31];

    always_comb begin
        state_d  = state;
        good     = 1'b0;
        bad      = 1'b0;
        cap      = 1'b0;
        tmo      = 1'b0;
        ovr      = bus.scan_en && (state == WR || state == RD);
        shift_en = bus.scan_en && (state == IDLE || state == SHIFT);
        start    = state == IDLE && bus.scan_en && !blocked;
        if (state == IDLE) begin
            state_d = start ? SHIFT : IDLE;
        end else if (state == SHIFT && !bus.scan_en) begin
            good    = cnt == 6'(FRAME_LEN);
            bad     = !good;
            state_d = bad ? IDLE : cmd[FRAME_LEN-1] ? WR : RD;
        end else if (state == WR) begin
            state_d = IDLE;
        end else if (state == RD) begin
            // a ready arriving on the last allowed cycle still counts as a capture
            cap     = bus.reg_ready;
            tmo     = !bus.reg_ready && tcnt == TW'(RD_TIMEOUT - 1);
            state_d = (cap || tmo) ? IDLE : RD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cmd             <= '0;
            rsr             <= '0;
            cnt             <= '0;
            tcnt            <= '0;
            blocked         <= 1'b0;
            bus.reg_wen     <= 1'b0;
            bus.reg_ren     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.rd_valid    <= 1'b0;
            bus.err_frame   <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.cr_wdata    <= '0;
        end else begin
            state       <= state_d;
            bus.busy    <= state_d != IDLE;
            bus.reg_wen <= state_d == WR;
            bus.reg_ren <= state_d == RD;
            if (start || (state == SHIFT && bus.scan_en))
                cmd <= {cmd[FRAME_LEN-2:0], bus.scan_in};
            cnt  <= start ? 6'd1 : (state == SHIFT && bus.scan_en && cnt != 6'd63) ? cnt + 6'd1 : cnt;
            tcnt <= (state == RD) ? tcnt + 1'b1 : '0;
            // bits arriving during an access stay ignored until scan_en is seen low in IDLE
            blocked         <= ovr ? 1'b1 : (state == IDLE && !bus.scan_en) ? 1'b0 : blocked;
            bus.err_frame   <= (bad || ovr) ? 1'b1 : good ? 1'b0 : bus.err_frame;
            bus.err_timeout <= cap ? 1'b0 : tmo ? 1'b1 : bus.err_timeout;
            if (good)
                bus.cr_wdata <= cmd[FRAME_LEN-2:0];
            rsr <= cap ? {bus.sr_rdata, bus.cr_rdata} : tmo ? '1 : (state == WR) ? '0 :
                   shift_en ? {rsr[30:0], 1'b0} : rsr;
            bus.rd_valid <= cap ? 1'b1 : (tmo || state == WR || shift_en) ? 1'b0 : bus.rd_valid;
        end
    end
endmodule

// File: tb/tb_scan_csr_master.sv
// tb_scan_csr_master: directed frames against a cycle-indexed model of strobes, busy and read-back data
module tb_scan_csr_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   exp_wen [0:2047];
    bit   exp_ren [0:2047];
    bit   exp_busy[0:2047];
    logic [31:0] exp_rb = '0;
    logic [16:0] cr_v;
    logic [14:0] sr_v;

    scan_csr_if bus();
    scan_csr_master dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    always @(negedge clk) if (cyc < 2048) begin
        chk("reg_wen", {31'b0, bus.reg_wen}, {31'b0, exp_wen[cyc]});
        chk("reg_ren", {31'b0, bus.reg_ren}, {31'b0, exp_ren[cyc]});
        chk("busy", {31'b0, bus.busy}, {31'b0, exp_busy[cyc]});
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // shifts nbits MSB first; n returns the cycle of the last bit, got collects scan_out
    task automatic send_frame(input int nbits, input logic [31:0] bits, output int n, output logic [31:0] got);
        got = '0;
        n = 0;
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            bus.scan_en = 1'b1;
            bus.scan_in = bits[nbits-1-i];
            exp_busy[cyc+1] = 1'b1;
            n = cyc;
            @(negedge clk);
            got = {got[30:0], bus.scan_out};
        end
        @(posedge clk); #1;
        bus.scan_en = 1'b0;
    endtask

    task automatic do_write(input logic [16:0] d);
        int n;
        logic [31:0] g;
        send_frame(18, {14'b0, 1'b1, d}, n, g);
        exp_wen[n+2]  = 1'b1;
        exp_busy[n+2] = 1'b1;
        exp_rb = '0;
        idle(3);
    endtask

    // lat: cycles from last frame bit to reg_ready; outside 2..9 means no ready at all
    task automatic do_read(input logic [16:0] d, input int lat, input bit ovr);
        int n, last, waited;
        logic [31:0] g;
        bit ok;
        send_frame(18, {14'b0, 1'b0, d}, n, g);
        ok = lat >= 2 && lat <= 9;
        last = ok ? lat : 9;
        for (int k = 2; k <= last; k++) begin
            exp_ren[n+k]  = 1'b1;
            exp_busy[n+k] = 1'b1;
        end
        exp_rb = ok ? {sr_v, cr_v} : 32'hFFFF_FFFF;
        waited = 1;
        if (ovr) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                bus.scan_en = 1'b1;
                bus.scan_in = 1'b1;
            end
            @(posedge clk); #1;
            bus.scan_en = 1'b0;
            waited = 5;
        end
        if (ok) begin
            repeat (lat - waited) @(posedge clk);
            #1 bus.reg_ready = 1'b1;
            @(posedge clk);
            #1 bus.reg_ready = 1'b0;
        end
        idle(ok ? 3 : 12);
    endtask

    task automatic readback(output logic [31:0] got);
        int n;
        send_frame(32, 32'h0, n, got);
        idle(3);
    endtask

    initial begin
        logic [31:0] g;
        int n;
        bus.scan_en = 1'b0;
        bus.scan_in = 1'b0;
        bus.reg_ready = 1'b0;
        cr_v = 17'h0F0F0;
        sr_v = 15'h1234;
        bus.cr_rdata = cr_v;
        bus.sr_rdata = sr_v;
        @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_rd_valid", {31'b0, bus.rd_valid}, 0);
        chk("rst_err_frame", {31'b0, bus.err_frame}, 0);
        chk("rst_err_timeout", {31'b0, bus.err_timeout}, 0);
        chk("rst_cr_wdata", {15'b0, bus.cr_wdata}, 0);
        chk("rst_scan_out", {31'b0, bus.scan_out}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        do_write(17'h1ABCD);
        chk("wr_cr_wdata", {15'b0, bus.cr_wdata}, 32'h1ABCD);
        chk("wr_err_frame", {31'b0, bus.err_frame}, 0);
        chk("wr_err_timeout", {31'b0, bus.err_timeout}, 0);

        send_frame(17, 32'h1FFFF, n, g);
        idle(3);
        chk("short_err_frame", {31'b0, bus.err_frame}, 1);
        chk("short_cr_wdata", {15'b0, bus.cr_wdata}, 32'h1ABCD);
        do_write(17'h00042);
        chk("wr2_err_frame", {31'b0, bus.err_frame}, 0);
        chk("wr2_cr_wdata", {15'b0, bus.cr_wdata}, 32'h00042);

        do_read(17'h00000, 3, 1'b0);
        chk("rd_valid", {31'b0, bus.rd_valid}, 1);
        chk("rd_err_timeout", {31'b0, bus.err_timeout}, 0);
        readback(g);
        chk("rb_literal", g, 32'h2468F0F0);
        chk("rb_model", g, exp_rb);
        chk("rb_rd_valid", {31'b0, bus.rd_valid}, 0);
        chk("rb_err_frame", {31'b0, bus.err_frame}, 1);

        do_write(17'h00001);
        do_read(17'h00003, 0, 1'b0);
        chk("to_err_timeout", {31'b0, bus.err_timeout}, 1);
        chk("to_rd_valid", {31'b0, bus.rd_valid}, 0);
        readback(g);
        chk("to_rb_literal", g, 32'hFFFFFFFF);

        cr_v = 17'h1FFFF;
        sr_v = 15'h0001;
        bus.cr_rdata = cr_v;
        bus.sr_rdata = sr_v;
        do_read(17'h00007, 9, 1'b0);
        chk("edge_err_timeout", {31'b0, bus.err_timeout}, 0);
        chk("edge_rd_valid", {31'b0, bus.rd_valid}, 1);
        readback(g);
        chk("edge_rb_literal", g, 32'h0003FFFF);
        chk("edge_rb_model", g, exp_rb);

        do_read(17'h05555, 6, 1'b1);
        chk("ovr_err_frame", {31'b0, bus.err_frame}, 1);
        chk("ovr_cr_wdata", {15'b0, bus.cr_wdata}, 32'h05555);
        chk("ovr_rd_valid", {31'b0, bus.rd_valid}, 1);
        do_write(17'h10001);
        chk("post_ovr_cr_wdata", {15'b0, bus.cr_wdata}, 32'h10001);
        chk("post_ovr_err_frame", {31'b0, bus.err_frame}, 0);

        send_frame(18, 32'h00011, n, g);
        exp_ren[n+2]  = 1'b1;
        exp_ren[n+3]  = 1'b1;
        exp_busy[n+2] = 1'b1;
        exp_busy[n+3] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_reg_ren", {31'b0, bus.reg_ren}, 0);
        chk("mid_rst_busy", {31'b0, bus.busy}, 0);
        chk("mid_rst_rd_valid", {31'b0, bus.rd_valid}, 0);
        chk("mid_rst_err_frame", {31'b0, bus.err_frame}, 0);
        chk("mid_rst_cr_wdata", {15'b0, bus.cr_wdata}, 0);
        chk("mid_rst_scan_out", {31'b0, bus.scan_out}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
